// File: rtl/note_sequencer.sv
// note_sequencer: walks a score memory and drives the tone divider with beat-timed notes and silent gaps
module note_sequencer #(
  parameter int BEAT_CYC = 12_500_000,
  parameter int GAP_CYC  = 1_000_000,
  parameter int ADDR_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              play,
  input  logic              pause,
  input  logic              stop,
  input  logic              loop_en,
  output logic [ADDR_W-1:0] score_addr,
  input  logic [25:0]       score_data,
  output logic [21:0]       note_div,
  output logic              playing,
  output logic              paused,
  output logic              done
);
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_LOAD, S_SOUND, S_GAP, S_PAUSED} state_t;
  state_t            r_state, r_saved, w_state, w_saved, w_adv_state;
  logic [31:0]       r_cnt, w_cnt, w_adv_cnt, w_note_len;
  logic [21:0]       r_saved_div, w_saved_div, w_div;
  logic [ADDR_W-1:0] w_addr, w_adv_addr;
  logic [3:0]        w_dur;
  logic              w_done, w_cnt_zero;

  assign w_dur      = score_data[25:22];
  assign w_note_len = 32'(w_dur) * 32'(BEAT_CYC) - 32'(GAP_CYC) - 32'd1;
  assign w_cnt_zero = r_cnt == 32'd0;

  // one counter step of SOUND/GAP; a pause consumes this step too, so pausing never adds or loses a cycle
  always_comb begin
    w_adv_state = r_state == S_SOUND ? (w_cnt_zero ? S_GAP : S_SOUND) : (w_cnt_zero ? S_FETCH : S_GAP);
    w_adv_cnt   = w_cnt_zero ? (r_state == S_SOUND ? 32'(GAP_CYC) - 32'd1 : 32'd0) : r_cnt - 32'd1;
    w_adv_addr  = (r_state == S_GAP && w_cnt_zero) ? score_addr + ADDR_W'(1) : score_addr;
  end

  // next-state and next-output logic; stop overrides everything, pause outranks play
  always_comb begin
    w_state     = r_state;
    w_saved     = r_saved;
    w_cnt       = r_cnt;
    w_addr      = score_addr;
    w_div       = note_div;
    w_saved_div = r_saved_div;
    w_done      = 1'b0;
    if (stop) begin
      w_state = S_IDLE;
      w_addr  = '0;
      w_div   = '0;
      w_cnt   = '0;
    end else begin
      case (r_state)
        S_IDLE:  w_state = play ? S_FETCH : S_IDLE;
        S_FETCH: w_state = S_LOAD;
        S_LOAD: begin
          if (w_dur != 4'd0) begin
            w_state = S_SOUND;
            w_div   = score_data[21:0];
            w_cnt   = w_note_len;
          end else begin
            w_addr  = '0;
            w_done  = score_addr == '0 || !loop_en;
            w_state = w_done ? S_IDLE : S_FETCH;
          end
        end
        S_SOUND, S_GAP: begin
          w_cnt   = w_adv_cnt;
          w_addr  = w_adv_addr;
          w_state = pause ? S_PAUSED : w_adv_state;
          w_div   = (w_adv_state == S_SOUND && !pause) ? note_div : '0;
          if (pause) begin
            w_saved     = w_adv_state;
            w_saved_div = note_div;
          end
        end
        S_PAUSED: begin
          if (pause || play) begin
            w_state = r_saved;
            w_div   = r_saved == S_SOUND ? r_saved_div : '0;
          end
        end
        default: w_state = S_IDLE;
      endcase
    end
  end

  // state, counter and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_saved     <= S_IDLE;
      r_cnt       <= '0;
      r_saved_div <= '0;
      score_addr  <= '0;
      note_div    <= '0;
      playing     <= 1'b0;
      paused      <= 1'b0;
      done        <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_saved     <= w_saved;
      r_cnt       <= w_cnt;
      r_saved_div <= w_saved_div;
      score_addr  <= w_addr;
      note_div    <= w_div;
      playing     <= w_state inside {S_FETCH, S_LOAD, S_SOUND, S_GAP};
      paused      <= w_state == S_PAUSED;
      done        <= w_done;
    end
  end
endmodule

// File: tb/tb_note_sequencer.sv
// tb_note_sequencer: scoreboard bench; a per-cycle playback model is run-length compressed into expected output segments
module tb_note_sequencer;
  localparam int BEAT = 10;
  localparam int GAP  = 2;
  localparam int AW   = 4;

  typedef struct {
    logic [28:0] t;
    int          len;
  } seg_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          play = 1'b0, pause = 1'b0, stop = 1'b0, loop_en = 1'b0;
  logic [AW-1:0] score_addr;
  logic [25:0]   score_data = '0;
  logic [21:0]   note_div;
  logic          playing, paused, done;
  logic [25:0]   mem [16];
  logic [28:0]   tl[$];
  bit            ph[$];
  seg_t          exp_q[$];
  int            total = 0, bad = 0;

  note_sequencer #(.BEAT_CYC(BEAT), .GAP_CYC(GAP), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .play(play), .pause(pause), .stop(stop), .loop_en(loop_en),
    .score_addr(score_addr), .score_data(score_data), .note_div(note_div),
    .playing(playing), .paused(paused), .done(done)
  );

  always #5 clk = ~clk;

  // synchronous score memory: data one cycle after address
  always @(posedge clk) score_data <= mem[score_addr];

  // output tuple: {div, addr, playing, paused, done}
  function automatic logic [28:0] pk(input logic [21:0] v, input int a, input logic [2:0] f);
    return {v, a[3:0], f};
  endfunction

  task automatic chk(input string nm, input logic [28:0] act, input logic [28:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, want);
    end
  endtask

  // unpaused playback timeline: two fetch/load cycles per entry, then sounding and gap cycles
  task automatic gen(input int lim);
    int          a, d;
    logic [25:0] e;
    logic [21:0] v;
    a = 0;
    tl.delete();
    ph.delete();
    while (tl.size() < lim) begin
      e = mem[a];
      d = int'(e[25:22]);
      v = e[21:0];
      repeat (2) begin tl.push_back(pk(22'd0, a, 3'b100)); ph.push_back(1'b0); end
      if (d == 0) begin
        if (a != 0 && loop_en) begin a = 0; continue; end
        tl.push_back(pk(22'd0, 0, 3'b001));
        ph.push_back(1'b0);
        break;
      end
      repeat (d * BEAT - GAP) begin tl.push_back(pk(v, a, 3'b100)); ph.push_back(1'b1); end
      repeat (GAP) begin tl.push_back(pk(22'd0, a, 3'b100)); ph.push_back(1'b1); end
      a = (a + 1) % 16;
    end
  endtask

  // insert pause window, cut at stop/reset, compress into non-idle segments
  task automatic push_exp(input int p, input int h, input int t);
    logic [28:0] x[$];
    logic [28:0] rt;
    int          rl;
    foreach (tl[i]) begin
      x.push_back(tl[i]);
      if (i == p) repeat (h) x.push_back(pk(22'd0, int'(tl[i+1][6:3]), 3'b010));
    end
    if (t >= 0) while (x.size() > t) void'(x.pop_back());
    x.push_back('0);
    rt = '0;
    rl = 0;
    foreach (x[i]) begin
      if (x[i] != rt) begin
        if (rt != '0) exp_q.push_back('{rt, rl});
        rt = x[i];
        rl = 1;
      end else rl++;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 3000) begin @(posedge clk); n++; end
    if (exp_q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: %0d segments left, want 0", exp_q.size());
      exp_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  // p/h: pause at cycle p for h cycles; t: first idle cycle after stop or async reset; ign: ignored play+pause
  task automatic scenario(input int p, input int h, input int t, input bit use_rst, input bit all3, input int ign);
    int last;
    push_exp(p, h, t);
    last = p + h;
    if (t > last) last = t;
    if (ign > last) last = ign;
    play = 1'b1;
    @(posedge clk);
    #1 play = 1'b0;
    for (int c = 0; c <= last; c++) begin
      pause = (p >= 0 && (c == p || c == p + h)) || c == ign;
      play  = c == ign;
      stop  = !use_rst && t > 0 && c == t - 1;
      if (all3 && stop) begin pause = 1'b1; play = 1'b1; end
      if (use_rst && c == t) begin
        #1 rst = 1'b0;
        #1 chk("rst_async", {note_div, score_addr, playing, paused, done}, '0);
      end
      @(posedge clk);
      #1;
      pause = 1'b0;
      play  = 1'b0;
      stop  = 1'b0;
      rst   = 1'b1;
    end
    drain();
  endtask

  // monitor: compares each completed non-idle output run against the scoreboard
  initial begin
    logic [28:0] rt, cur;
    int          rl;
    seg_t        e;
    rt = '0;
    rl = 0;
    forever begin
      @(negedge clk);
      cur = {note_div, score_addr, playing, paused, done};
      if (cur === rt) rl++;
      else begin
        if (rt != '0) begin
          total++;
          if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL seg_extra: got %h x%0d, nothing expected", rt, rl);
          end else begin
            e = exp_q.pop_front();
            if (e.t !== rt || e.len != rl) begin
              bad++;
              $display("FAIL seg: got %h x%0d want %h x%0d", rt, rl, e.t, e.len);
            end
          end
        end
        rt = cur;
        rl = 1;
      end
    end
  end

  initial begin
    int idx, n, p, h, t, ign, base;
    for (int i = 0; i < 16; i++) mem[i] = '0;
    #2 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk("reset", {note_div, score_addr, playing, paused, done}, '0);
    rst = 1'b1;
    @(posedge clk);
    #1 pause = 1'b1;
    @(posedge clk);
    #1 pause = 1'b0;
    chk("idle_pause", {note_div, score_addr, playing, paused, done}, '0);

    mem[0] = {4'd2, 22'd100};
    mem[1] = {4'd1, 22'd0};
    mem[2] = '0;
    loop_en = 1'b0;
    gen(2000); scenario(-1, 0, -1, 1'b0, 1'b0, -1);
    loop_en = 1'b1;
    gen(200);  scenario(-1, 0, 80, 1'b0, 1'b0, -1);
    loop_en = 1'b0;
    gen(2000); scenario(6, 7, -1, 1'b0, 1'b0, -1);

    for (int i = 0; i < 5; i++) mem[i] = {4'd1, 22'(i * 37 + 5)};
    mem[5] = '0;
    gen(2000);
    idx = 0;
    for (int i = 0; i < tl.size(); i++)
      if (tl[i][6:3] == 4'd3 && ph[i] && tl[i][28:7] == 22'd0) begin idx = i; break; end
    scenario(-1, 0, idx + 1, 1'b0, 1'b0, -1);
    scenario(-1, 0, -1, 1'b0, 1'b0, -1);

    mem[0] = '0;
    loop_en = 1'b1;
    gen(2000); scenario(-1, 0, -1, 1'b0, 1'b0, -1);

    mem[0] = {4'd2, 22'd55};
    mem[1] = '0;
    loop_en = 1'b0;
    gen(2000); scenario(-1, 0, 7, 1'b0, 1'b1, -1);
    gen(2000); scenario(-1, 0, 10, 1'b1, 1'b0, -1);

    for (int i = 0; i < 16; i++) mem[i] = {4'd1, 22'($urandom_range(1, 4194303))};
    gen(240); scenario(-1, 0, 212, 1'b0, 1'b0, -1);

    repeat (20) begin
      n = $urandom_range(1, 6);
      for (int i = 0; i < 16; i++) mem[i] = '0;
      for (int i = 0; i < n; i++)
        mem[i] = {4'($urandom_range(1, 3)), ($urandom_range(0, 3) == 0) ? 22'd0 : 22'($urandom_range(1, 4194303))};
      loop_en = 1'($urandom_range(0, 1));
      gen(300);
      p = -1;
      h = 0;
      t = -1;
      ign = $urandom_range(0, 1);
      if ($urandom_range(0, 1) == 1) begin
        p = $urandom_range(2, 100);
        while (p < tl.size() - 1 && !ph[p]) p++;
        if (p >= tl.size() - 1) p = -1;
        else h = $urandom_range(1, 10);
      end
      if (loop_en || $urandom_range(0, 1) == 1) begin
        base = (p >= 0) ? p + h + 2 : 3;
        t = base + $urandom_range(0, 60);
      end
      scenario(p, h, t, 1'b0, 1'b0, ign);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/note_sequencer.md
# note_sequencer

Score-playback controller that sequences the tone datapath: it walks a synchronous score memory, converts each entry's duration into beat-timed intervals, and drives the 22-bit `note_div` word consumed by the speaker/buzzer chain. Between notes it inserts a short silent gap so repeated notes remain audible. It accepts play/pause/stop pulses from the debounced, one-pulsed board buttons and supports looped or one-shot playback.

## Interface
- `BEAT_CYC`, 12_500_000, clk cycles per beat (1/8 s at 100 MHz); must be > GAP_CYC
- `GAP_CYC`, 1_000_000, silent cycles at the end of every note (10 ms)
- `ADDR_W`, 8, score memory address width
- `clk`  input  1  system clock (100 MHz)
- `rst`  input  1  asynchronous, active-low reset
- `play`  input  1  1-cycle pulse: start from IDLE, or resume from PAUSED
- `pause`  input  1  1-cycle pulse: toggle pause while a note is sounding
- `stop`  input  1  1-cycle pulse: abort, return to address 0
- `loop_en`  input  1  level; 1 = restart at end marker, 0 = one-shot
- `score_addr`  output  ADDR_W  score memory address (registered)
- `score_data`  input  26  {dur[25:22], div[21:0]}; valid 1 cycle after `score_addr`
- `note_div`  output  22  divider to speaker chain; 0 = silence
- `playing`  output  1  high in FETCH/LOAD/SOUND/GAP
- `paused`  output  1  high in PAUSED
- `done`  output  1  1-cycle pulse on one-shot completion or empty score

## Operation
- Score entry: `dur` = length in beats (1..15); `dur`=0 is the end marker. `div`=0 is a rest (sounds silence for the whole entry).
- States: IDLE, FETCH, LOAD, SOUND, GAP, PAUSED. Reset: IDLE, `score_addr`=0, `note_div`=0, `playing`=0, `paused`=0, `done`=0, counter=0.
- IDLE: `play` -> FETCH. `pause` ignored.
- FETCH: one cycle, address stable -> LOAD.
- LOAD: sample `score_data`.
  - dur≠0: `note_div`<=div, counter<=dur*BEAT_CYC-GAP_CYC-1, -> SOUND.
  - dur=0 at `score_addr`=0 (empty score): -> IDLE, `done` pulse, regardless of `loop_en`.
  - dur=0 otherwise: `loop_en`=1 -> `score_addr`<=0, FETCH; `loop_en`=0 -> IDLE, `score_addr`<=0, `done` pulse.
- SOUND: counter decrements; at 0 -> GAP, `note_div`<=0, counter<=GAP_CYC-1.
- GAP: counter decrements; at 0 -> `score_addr`<=`score_addr`+1 (wraps modulo 2^ADDR_W to 0, playback continues), FETCH.
- PAUSED: entered by `pause` in SOUND or GAP; counter frozen, `note_div`=0, saved state (SOUND/GAP) and saved div held. `pause` or `play` resumes to saved state; in SOUND, `note_div` restored to saved div on the resume edge. `pause` in FETCH/LOAD ignored.
- `stop` from any state: -> IDLE, `score_addr`<=0, `note_div`<=0, counter<=0. Priority on coincident pulses: stop > pause > play. `play` while playing ignored.
- Counter 32 bits unsigned; dur*BEAT_CYC computed as shift-add or constant multiply, no overflow for dur≤15 at default parameters.

## Timing
- All outputs registered; `done` high exactly one cycle.
- `play` sampled at edge k -> FETCH after k; LOAD after k+1; `note_div` valid after edge k+2.
- Note of `dur` beats: `note_div`=div for dur*BEAT_CYC-GAP_CYC cycles, then 0 for GAP_CYC cycles, then 2 cycles (FETCH, LOAD) before next note; entry period = dur*BEAT_CYC+2 cycles.
- Pause/resume: zero lost or added counter cycles; total sounding time unchanged apart from time spent PAUSED.
- `rst` deassertion mid-note: block idle and silent; async assertion clears all state immediately.

## Test plan
(BEAT_CYC=10, GAP_CYC=2, ADDR_W=4)
- Score {dur2,div100},{dur1,div0},{dur0}, loop_en=0, play -> `note_div`=100 for 18 cycles, 0 for 2, 0 for 10+2 (rest), `done` pulse, IDLE, `score_addr`=0.
- Same score, loop_en=1 -> pattern repeats; `score_addr` sequence 0,1,2,0,1…; `done` never asserted.
- Pause at cycle 5 of a 2-beat note, hold 7 cycles, pause again -> `note_div`=0 during pause, remaining 13 sounding cycles delivered after resume.
- Stop during GAP of entry 3 -> next edge IDLE, `note_div`=0, `score_addr`=0; subsequent play restarts at entry 0.
- Empty score (dur0 at address 0), loop_en=1, play -> single `done` pulse, back in IDLE, no refetch loop.
- Coincident stop+pause+play in SOUND -> stop wins; rst pulse mid-SOUND -> all outputs at reset values.
